generic_sync_fifo: RTL

- Parameterised single-clock first-word-fall-through FIFO with valid/ready handshakes on both sides.
- Sits directly upstream of the enable-gated pipeline registers in the trace/debug datapath.
- Absorbs bursts from a producer and presents one word per cycle; a downstream register captures that word with `en = rd_valid & rd_ready`.
- Also reports occupancy and an almost-full early warning for upstream throttling.

---
 rtl/generic_sync_fifo.sv | 73 +++++++
 1 files changed

// File: rtl/generic_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with valid/ready on both sides.
// Ports: clk, rst (sync, active-high), flush (sync clear);
//   write side wr_valid/wr_data/wr_ready; read side rd_valid/rd_data/rd_ready;
//   status count (0..DEPTH) and almost_full (count >= AFULL_THRESH).
module generic_sync_fifo #(
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 4,
  parameter int AFULL_THRESH = DEPTH - 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       wr_valid,
  input  logic [WIDTH-1:0]           wr_data,
  output logic                       wr_ready,
  output logic                       rd_valid,
  output logic [WIDTH-1:0]           rd_data,
  input  logic                       rd_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       almost_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AFULL_THRESH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;
  logic             clr;

  // Status depends only on registered count, so wr_ready has
  // no combinational path from rd_ready.
  assign wr_ready    = (count != FULL_CNT);
  assign rd_valid    = (count != '0);
  assign almost_full = (count >= AF_CNT);
  assign rd_data     = rd_valid ? mem[rd_ptr] : '0;

  assign clr  = rst | flush;
  assign push = wr_valid & wr_ready & ~clr;
  assign pop  = rd_valid & rd_ready & ~clr;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
